// File: rtl/bist_pkg.sv
// Shared types and default parameters for the BIST response compactor.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int          DEF_CHAIN_LEN = 8;
    localparam int          DEF_SIG_W     = 16;
    localparam logic [15:0] DEF_POLY      = 16'h1021;
    localparam logic [15:0] DEF_SEED      = 16'h0000;

endpackage

// File: rtl/sisr_step.sv
// One serial step of the signature register: shift left, fold in a response bit.
module sisr_step #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic [SIG_W-1:0] sig,
    input  logic             bit_in,
    output logic [SIG_W-1:0] sig_next
);

    logic fb;

    // The x^SIG_W term is implicit: the bit shifted out only steers feedback.
    assign fb       = sig[SIG_W-1] ^ bit_in;
    assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/bist_signature_analyzer.sv
// Compacts scan unload bits into a SISR and reports pass/fail after NUM_PATTERNS unloads.
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int               CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int               NUM_PATTERNS = 16,
    parameter int               SIG_W        = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY         = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED         = DEF_SEED,
    parameter logic [SIG_W-1:0] GOLDEN       = 16'h0000,
    localparam int              CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             scan_out,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             proto_err
);

    localparam int               BIT_W      = $clog2(CHAIN_LEN + 1);
    localparam logic [BIT_W-1:0] CHAIN_FULL = BIT_W'(CHAIN_LEN);
    localparam logic [BIT_W-1:0] CHAIN_LAST = BIT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PAT_LAST   = CNT_W'(NUM_PATTERNS - 1);

    state_e           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [SIG_W-1:0] sig_next;

    sisr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_sisr_step (
        .sig      (signature),
        .bit_in   (scan_out),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            signature   <= SEED;
            bit_cnt     <= '0;
            pattern_cnt <= '0;
            proto_err   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                // Shifts here are the initial load of junk; wait for the first capture.
                IDLE: begin
                    if (!scan_en) begin
                        state   <= COLLECT;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (scan_en) begin
                        if (bit_cnt != CHAIN_FULL) begin
                            signature <= sig_next;
                            bit_cnt   <= bit_cnt + 1'b1;
                            // Last bit of an unload: count it and possibly finish on this edge.
                            if (bit_cnt == CHAIN_LAST) begin
                                pattern_cnt <= pattern_cnt + 1'b1;
                                if (pattern_cnt == PAT_LAST) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    pass  <= (sig_next == GOLDEN) && !proto_err;
                                end
                            end
                        end
                    end else begin
                        bit_cnt <= '0;
                        // A capture mid-unload means the tester shifted too few bits.
                        if (bit_cnt != '0 && bit_cnt != CHAIN_FULL) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer: a 1-pattern and a 16-pattern instance share stimulus.
module tb_bist_signature_analyzer;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic        scan_out;

    logic [15:0] sig1;
    logic [0:0]  pcnt1;
    logic        busy1, done1, pass1, perr1;

    logic [15:0] sig16;
    logic [4:0]  pcnt16;
    logic        busy16, done16, pass16, perr16;

    int errors = 0;
    int checks = 0;

    bist_signature_analyzer #(
        .CHAIN_LEN    (8),
        .NUM_PATTERNS (1),
        .SIG_W        (16),
        .POLY         (16'h1021),
        .SEED         (16'h0000),
        .GOLDEN       (16'h9188)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .scan_out    (scan_out),
        .signature   (sig1),
        .pattern_cnt (pcnt1),
        .busy        (busy1),
        .done        (done1),
        .pass        (pass1),
        .proto_err   (perr1)
    );

    bist_signature_analyzer #(
        .CHAIN_LEN    (8),
        .NUM_PATTERNS (16),
        .SIG_W        (16),
        .POLY         (16'h1021),
        .SEED         (16'h0000),
        .GOLDEN       (16'h0000)
    ) dut16 (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .scan_out    (scan_out),
        .signature   (sig16),
        .pattern_cnt (pcnt16),
        .busy        (busy16),
        .done        (done16),
        .pass        (pass16),
        .proto_err   (perr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic se, input logic so);
        scan_en  = se;
        scan_out = so;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step(i[0], 1'b1);
        rst = 1'b0;
    endtask

    task automatic zero_pattern;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        scan_en  = 1'b0;
        scan_out = 1'b0;

        // Reset with scan_en toggling
        do_reset(2);
        check("rst_sig",   32'(sig1),   32'h0000);
        check("rst_done",  32'(done1),  32'd0);
        check("rst_busy",  32'(busy1),  32'd0);
        check("rst_pcnt",  32'(pcnt16), 32'd0);
        check("rst_perr",  32'(perr16), 32'd0);
        check("rst_pass",  32'(pass1),  32'd0);

        // Single pattern 1,0,0,0,0,0,0,0 after a junk load
        for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)));
        check("load_ignored_sig",  32'(sig16), 32'h0000);
        check("load_ignored_busy", 32'(busy16), 32'd0);
        step(1'b0, 1'b0);
        check("capture_busy", 32'(busy16), 32'd1);
        step(1'b1, 1'b1);
        check("sig_bit1", 32'(sig1), 32'h1021);
        step(1'b1, 1'b0);
        check("sig_bit2", 32'(sig1), 32'h2042);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("sig_bit5", 32'(sig1), 32'h1231);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("sig_bit8",     32'(sig1),   32'h9188);
        check("p1_done",      32'(done1),  32'd1);
        check("p1_pass",      32'(pass1),  32'd1);
        check("p1_busy",      32'(busy1),  32'd0);
        check("p1_pcnt",      32'(pcnt1),  32'd1);
        check("p16_not_done", 32'(done16), 32'd0);
        check("p16_pcnt",     32'(pcnt16), 32'd1);
        // DONE is frozen
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("frozen_sig",  32'(sig1),  32'h9188);
        check("frozen_pcnt", 32'(pcnt1), 32'd1);
        check("frozen_done", 32'(done1), 32'd1);

        // All-zero response over 16 patterns with extra back-to-back captures
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int p = 0; p < 15; p++) zero_pattern();
        step(1'b0, 1'b0);
        check("zero_pcnt15", 32'(pcnt16), 32'd15);
        check("zero_busy",   32'(busy16), 32'd1);
        check("zero_perr",   32'(perr16), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("zero_sig",   32'(sig16),  32'h0000);
        check("zero_pcnt",  32'(pcnt16), 32'd16);
        check("zero_done",  32'(done16), 32'd1);
        check("zero_pass",  32'(pass16), 32'd1);
        check("zero_p1_pass_mismatch", 32'(pass1), 32'd0);
        // pattern_cnt must not wrap past NUM_PATTERNS
        zero_pattern();
        check("zero_pcnt_hold", 32'(pcnt16), 32'd16);

        // Short unload: 5 shifts then capture
        do_reset(1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("short_perr", 32'(perr16), 32'd1);
        check("short_pcnt", 32'(pcnt16), 32'd0);
        for (int p = 0; p < 16; p++) zero_pattern();
        check("short_done", 32'(done16), 32'd1);
        check("short_sig",  32'(sig16),  32'h0000);
        check("short_pass", 32'(pass16), 32'd0);

        // Surplus shifts: 12 shifts, only the first 8 compacted
        do_reset(1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        check("surplus_sig",  32'(sig16),  32'h9188);
        check("surplus_pcnt", 32'(pcnt16), 32'd1);
        step(1'b0, 1'b0);
        check("surplus_perr", 32'(perr16), 32'd0);
        step(1'b1, 1'b1);
        check("second_bit1", 32'(sig16), 32'h2310);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        check("second_sig",  32'(sig16),  32'h8A10);
        check("second_pcnt", 32'(pcnt16), 32'd2);

        // Reset mid-run at pattern 3 bit 4
        do_reset(1);
        step(1'b0, 1'b0);
        zero_pattern();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        zero_pattern();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        check("mid_sig",  32'(sig16),  32'hF1EF);
        check("mid_pcnt", 32'(pcnt16), 32'd2);
        check("mid_perr", 32'(perr16), 32'd1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        check("abort_sig",  32'(sig16),  32'h0000);
        check("abort_pcnt", 32'(pcnt16), 32'd0);
        check("abort_perr", 32'(perr16), 32'd0);
        check("abort_busy", 32'(busy16), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        check("rerun_sig",  32'(sig1),  32'h9188);
        check("rerun_done", 32'(done1), 32'd1);
        check("rerun_pass", 32'(pass1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_signature_analyzer.md
Name: bist_signature_analyzer

Overview:
Response compactor directly downstream of Built_In_Self_Test. It monitors the same scan_en as the scan chain and samples scan_out during every unload shift. Unloaded bits are folded into a serial CRC-style signature register (SISR). After NUM_PATTERNS complete unloads it freezes the signature and reports pass/fail against a golden value.

Parameters:
CHAIN_LEN, 8, scan chain length = shift cycles per unload
NUM_PATTERNS, 16, complete unloads compacted before done
SIG_W, 16, signature register width
POLY, 16'h1021, feedback polynomial, x^SIG_W term implicit
SEED, 16'h0000, signature value after reset
GOLDEN, 16'h0000, expected final signature (set per test program)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
scan_en  in  1  1 = shift/unload cycle, 0 = capture cycle (shared with scan chain)
scan_out  in  1  serial response bit from last chain flop
signature  out  SIG_W  current SISR contents
pattern_cnt  out  CNT_W  completed unloads; CNT_W = $clog2(NUM_PATTERNS+1)
busy  out  1  high in COLLECT
done  out  1  high in DONE
pass  out  1  done && signature==GOLDEN && !proto_err
proto_err  out  1  sticky short-unload flag

Behaviour:
- Reset (rst sampled high at clk edge): state=IDLE, signature=SEED, bit_cnt=0, pattern_cnt=0, proto_err=0. All outputs low except signature=SEED. rst mid-run aborts immediately with no partial result retained.
- IDLE: scan_en=1 cycles are the initial load (chain holds junk) and are ignored. The first scan_en=0 (capture) cycle -> COLLECT, bit_cnt=0.
- COLLECT, scan_en=1 and bit_cnt<CHAIN_LEN:
  - fb = signature[SIG_W-1] ^ scan_out
  - signature <= {signature[SIG_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - bit_cnt++
  - When bit_cnt reaches CHAIN_LEN on this edge, pattern_cnt++ on the same edge.
  - If pattern_cnt becomes NUM_PATTERNS -> DONE on that edge. The final compaction and the DONE entry occur together.
- COLLECT, scan_en=1 and bit_cnt==CHAIN_LEN: surplus shift. Bit ignored, no counter change.
- COLLECT, scan_en=0 (capture):
  - bit_cnt <= 0.
  - If 0<bit_cnt<CHAIN_LEN: proto_err <= 1 (sticky). The partial pattern is not counted, but its bits stay in the signature.
  - Back-to-back captures with bit_cnt==0 are legal, no error.
- DONE: signature, pattern_cnt, proto_err frozen. scan_en/scan_out ignored. done=1, busy=0. Exit only via rst.
- Latency: signature reflects a sampled bit one edge after sampling. done/pass assert the cycle after the last unload edge (registered outputs, no combinational path from scan_out).
- Bit order: the first compacted bit of each unload is the chain's last-flop contents at capture.
- pattern_cnt never exceeds NUM_PATTERNS; no wrap.

Decomposition:
- Shared package bist_pkg: state enum {IDLE, COLLECT, DONE}, default CHAIN_LEN, SIG_W, POLY, SEED.
- One natural sub-module: sisr_step, a combinational next-signature function (sig, bit, POLY) -> next sig, reused by the bench model.
- Counters and FSM stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with scan_en toggling -> signature=0x0000, done=0, busy=0, pattern_cnt=0, proto_err=0.
- Single pattern (NUM_PATTERNS=1, SEED=0): 8 load shifts, capture, unload scan_out=1,0,0,0,0,0,0,0.
  - signature=0x1021 after the first bit, 0x9188 after the eighth.
  - done=1 next cycle; pass=1 iff GOLDEN=0x9188.
- All-zero response: NUM_PATTERNS=16, scan_out held 0 -> signature stays 0x0000, pattern_cnt=16, done=1, pass=1 with GOLDEN=0.
- Short unload: capture after 5 shifts in COLLECT -> proto_err=1, pattern_cnt unchanged. With GOLDEN matching, pass=0 at done.
- Surplus shifts: 12 scan_en=1 cycles between captures -> only the first 8 compacted; signature equals the 8-bit-unload model.
- Reset mid-run: rst at pattern 3 bit 4 -> outputs return to reset values next edge. A fresh 1-pattern run then reproduces 0x9188.
